// File: rtl/display_scan_ctrl_if.sv
// Display controller bus: value and mode request in, multiplexed
// seven-segment drive and status out.
interface display_scan_ctrl_if #(
   parameter int NUM_DIGITS = 4,
   parameter int RESULT_W   = 8
);
   logic signed [RESULT_W-1:0] result;
   logic                       mode_change;
   logic [6:0]                 seg;
   logic [NUM_DIGITS-1:0]      an;
   logic                       hex_mode;
   logic                       busy;

   modport master (output result, mode_change, input seg, an, hex_mode, busy);
   modport slave  (input result, mode_change, output seg, an, hex_mode, busy);
endinterface

// File: rtl/display_scan_ctrl.sv
// Signed value -> multiplexed seven-segment display (decimal or hex).
// Optional LEADING_ZERO_BLANK_EN blanks zeros above the most significant digit.

module display_scan_digit (
   input  logic [3:0] nib,
   input  logic       blank,
   input  logic       ovf,
   output logic [6:0] glyph
);
   always_comb begin
      glyph = 7'b1111111;
      case (nib)
         4'h0: glyph = 7'b1000000;
         4'h1: glyph = 7'b1111001;
         4'h2: glyph = 7'b0100100;
         4'h3: glyph = 7'b0110000;
         4'h4: glyph = 7'b0011001;
         4'h5: glyph = 7'b0010010;
         4'h6: glyph = 7'b0000010;
         4'h7: glyph = 7'b1111000;
         4'h8: glyph = 7'b0000000;
         4'h9: glyph = 7'b0010000;
         4'hA: glyph = 7'b0001000;
         4'hB: glyph = 7'b0000011;
         4'hC: glyph = 7'b1000110;
         4'hD: glyph = 7'b0100001;
         4'hE: glyph = 7'b0000110;
         default: glyph = 7'b0001110;
      endcase
      if (ovf)        glyph = 7'b0111111;
      else if (blank) glyph = 7'b1111111;
   end
endmodule

module display_scan_ctrl #(
   parameter int NUM_DIGITS  = 4,
   parameter int RESULT_W    = 8,
   parameter int REFRESH_DIV = 100000
) (
   input  logic              clk,
   input  logic              reset,
   display_scan_ctrl_if.slave bus
);
   localparam logic [6:0] G_BLANK = 7'b1111111;
   localparam logic [6:0] G_MINUS = 7'b0111111;
   localparam int MAG_N = NUM_DIGITS - 1;
   // BCD digits able to hold any RESULT_W-bit magnitude, so overflow is visible
   localparam int BCD_N = (RESULT_W + 2) / 3;
   localparam int SR_N  = (BCD_N > MAG_N) ? BCD_N : MAG_N;
   localparam int SR_W  = 4 * SR_N + RESULT_W;
   localparam int CNT_W = $clog2(RESULT_W + 1);
   localparam int RC_W  = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = $clog2(NUM_DIGITS);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   state_t                       state;
   logic                         busy_q, first_q, last_hex, neg_q, hex_q;
   logic                         mc_q, hex_mode_q;
   logic [RESULT_W-1:0]          res_u, mag_c, last_val;
   logic [SR_W-1:0]              sr_q;
   logic [4*SR_N-1:0]            bcd, adj;
   logic [CNT_W-1:0]             cnt;
   logic                         ovf;
   logic [MAG_N-1:0]             blank;
   logic [MAG_N-1:0][6:0]        glyph_c;
   logic [6:0]                   sign_g;
   logic [NUM_DIGITS-1:0][6:0]   dig_q;
   logic [RC_W-1:0]              rcnt;
   logic [IDX_W-1:0]             idx;
   logic [NUM_DIGITS-1:0]        an_q;
   logic [6:0]                   seg_q;

   assign res_u = bus.result;
   // Two's-complement negate as unsigned: the most negative value maps to 2^(W-1)
   assign mag_c = res_u[RESULT_W-1] ? (~res_u + RESULT_W'(1)) : res_u;
   assign bcd   = sr_q[SR_W-1:RESULT_W];

   always_comb begin
      adj = bcd;
      if (!hex_q)
         for (int i = 0; i < SR_N; i++)
            if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
   end

   always_comb begin
      ovf = 1'b0;
      for (int i = MAG_N; i < SR_N; i++)
         if (bcd[4*i +: 4] != 4'd0) ovf = 1'b1;
   end

`ifdef LEADING_ZERO_BLANK_EN
   always_comb begin
      logic run;
      run   = 1'b1;
      blank = '0;
      for (int i = MAG_N - 1; i >= 0; i--) begin
         if (bcd[4*i +: 4] != 4'd0) run = 1'b0;
         blank[i] = run && (i != 0);
      end
   end
`else
   assign blank = '0;
`endif

   for (genvar g = 0; g < MAG_N; g++) begin : g_dig
      display_scan_digit u_dig (
         .nib   (bcd[4*g +: 4]),
         .blank (blank[g]),
         .ovf   (ovf),
         .glyph (glyph_c[g])
      );
   end

   assign sign_g = (ovf || neg_q) ? G_MINUS : G_BLANK;

   // Converter: result/mode are captured in LOAD, so later input changes only
   // take effect through a fresh pass from IDLE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         busy_q   <= 1'b0;
         first_q  <= 1'b1;
         last_val <= '0;
         last_hex <= 1'b0;
         neg_q    <= 1'b0;
         hex_q    <= 1'b0;
         sr_q     <= '0;
         cnt      <= '0;
         dig_q    <= {NUM_DIGITS{G_BLANK}};
      end else begin
         case (state)
            IDLE: if (first_q || res_u != last_val || hex_mode_q != last_hex) begin
               state   <= LOAD;
               busy_q  <= 1'b1;
               first_q <= 1'b0;
            end
            LOAD: begin
               last_val <= res_u;
               last_hex <= hex_mode_q;
               neg_q    <= res_u[RESULT_W-1];
               hex_q    <= hex_mode_q;
               sr_q     <= {{(4*SR_N){1'b0}}, mag_c};
               cnt      <= '0;
               state    <= SHIFT;
            end
            SHIFT: begin
               sr_q <= {adj, sr_q[RESULT_W-1:0]} << 1;
               cnt  <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(RESULT_W - 1)) state <= DONE;
            end
            default: begin
               dig_q  <= {sign_g, glyph_c};
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mc_q       <= 1'b0;
         hex_mode_q <= 1'b0;
      end else begin
         mc_q <= bus.mode_change;
         if (bus.mode_change && !mc_q) hex_mode_q <= ~hex_mode_q;
      end
   end

   // an and seg are both registered from the same index so they stay aligned
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rcnt  <= '0;
         idx   <= '0;
         an_q  <= '1;
         seg_q <= G_BLANK;
      end else begin
         if (rcnt == RC_W'(REFRESH_DIV - 1)) begin
            rcnt <= '0;
            idx  <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
         end else begin
            rcnt <= rcnt + RC_W'(1);
         end
         an_q  <= ~(NUM_DIGITS'(1) << idx);
         seg_q <= dig_q[idx];
      end
   end

   assign bus.seg      = seg_q;
   assign bus.an       = an_q;
   assign bus.hex_mode = hex_mode_q;
   assign bus.busy     = busy_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench: a 4-digit and a 3-digit controller driven with the same value.
module tb_display_scan_ctrl;
   localparam logic [6:0] GB = 7'b1111111;
   localparam logic [6:0] GM = 7'b0111111;
   localparam logic [6:0] G1 = 7'b1111001;
   localparam logic [6:0] G2 = 7'b0100100;
   localparam logic [6:0] G5 = 7'b0010010;
   localparam logic [6:0] G7 = 7'b1111000;
   localparam logic [6:0] G8 = 7'b0000000;
   localparam logic [6:0] G9 = 7'b0010000;
   localparam logic [6:0] GHB = 7'b0000011;
`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] GZ = 7'b1111111;
`else
   localparam logic [6:0] GZ = 7'b1000000;
`endif

   logic clk = 1'b0;
   logic reset;
   logic signed [7:0] result;
   logic mode_change;
   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   display_scan_ctrl_if #(.NUM_DIGITS(4), .RESULT_W(8)) d4_if ();
   display_scan_ctrl_if #(.NUM_DIGITS(3), .RESULT_W(8)) d3_if ();
   assign d4_if.result = result;
   assign d4_if.mode_change = mode_change;
   assign d3_if.result = result;
   assign d3_if.mode_change = mode_change;

   display_scan_ctrl #(.NUM_DIGITS(4), .RESULT_W(8), .REFRESH_DIV(4)) u_dut4 (
      .clk(clk), .reset(reset), .bus(d4_if.slave));
   display_scan_ctrl #(.NUM_DIGITS(3), .RESULT_W(8), .REFRESH_DIV(4)) u_dut3 (
      .clk(clk), .reset(reset), .bus(d3_if.slave));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic get_digit(input int which, input int idx, output logic [6:0] g);
      logic [3:0] w4;
      logic [2:0] w3;
      bit hit;
      w4 = ~(4'b0001 << idx);
      w3 = ~(3'b001 << idx);
      hit = 1'b0;
      g = '1;
      for (int k = 0; k < 64 && !hit; k++) begin
         @(negedge clk);
         if (which == 0 && d4_if.an == w4) begin g = d4_if.seg; hit = 1'b1; end
         else if (which == 1 && d3_if.an == w3) begin g = d3_if.seg; hit = 1'b1; end
      end
      if (!hit) chk("scan_timeout", 32'd0, 32'd1);
   endtask

   task automatic chk_dig4(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                           input logic [6:0] e1, input logic [6:0] e0);
      logic [6:0] g;
      get_digit(0, 0, g); chk({tag, "_d0"}, 32'(g), 32'(e0));
      get_digit(0, 1, g); chk({tag, "_d1"}, 32'(g), 32'(e1));
      get_digit(0, 2, g); chk({tag, "_d2"}, 32'(g), 32'(e2));
      get_digit(0, 3, g); chk({tag, "_d3"}, 32'(g), 32'(e3));
   endtask

   // Waits for busy to rise, then returns how many cycles it stayed high.
   task automatic busy_len(output int n);
      int w;
      n = 0;
      w = 0;
      while (d4_if.busy !== 1'b1 && w < 20) begin @(negedge clk); w++; end
      while (d4_if.busy === 1'b1 && n < 40) begin n++; @(negedge clk); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired CHECKS %0d ERRORS %0d", n_chk, n_err);
      $fatal(1);
   end

   initial begin
      int n;
      logic [6:0] g;
      reset = 1'b0;
      result = 8'sd5;
      mode_change = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_an", 32'(d4_if.an), 32'hF);
      chk("rst_seg", 32'(d4_if.seg), 32'(GB));
      chk("rst_hex", 32'(d4_if.hex_mode), 32'd0);
      chk("rst_busy", 32'(d4_if.busy), 32'd0);

      reset = 1'b1;
      chk("busy_pre", 32'(d4_if.busy), 32'd0);
      busy_len(n);
      chk("busy_len_p5", 32'(n), 32'd10);
      chk_dig4("p5", GB, GZ, GZ, G5);

      result = -8'sd5;
      repeat (30) @(negedge clk);
      chk_dig4("m5", GM, GZ, GZ, G5);

      result = -8'sd11;
      mode_change = 1'b1;
      repeat (5) @(negedge clk);
      chk("hex_held", 32'(d4_if.hex_mode), 32'd1);
      mode_change = 1'b0;
      repeat (40) @(negedge clk);
      chk("hex_after", 32'(d4_if.hex_mode), 32'd1);
      chk_dig4("hex_m11", GM, GZ, GZ, GHB);

      mode_change = 1'b1;
      @(negedge clk);
      mode_change = 1'b0;
      result = -8'sd128;
      repeat (40) @(negedge clk);
      chk("dec_back", 32'(d4_if.hex_mode), 32'd0);
      chk_dig4("m128", GM, G1, G2, G8);
      get_digit(1, 0, g); chk("ovf_d0", 32'(g), 32'(GM));
      get_digit(1, 1, g); chk("ovf_d1", 32'(g), 32'(GM));
      get_digit(1, 2, g); chk("ovf_d2", 32'(g), 32'(GM));

      // Align to the scan so digit 0 is lit right after the first conversion lands
      n = 0;
      while (d4_if.an == 4'b1101 && n < 40) begin @(negedge clk); n++; end
      while (d4_if.an != 4'b1101 && n < 40) begin @(negedge clk); n++; end
      chk("align_timeout", 32'(n < 40), 32'd1);
      result = 8'sd5;
      repeat (4) @(negedge clk);
      result = 8'sd7;
      get_digit(0, 0, g);
      chk("mid_first", 32'(g), 32'(G5));
      repeat (40) @(negedge clk);
      chk_dig4("mid_second", GB, GZ, GZ, G7);

      result = 8'sd9;
      repeat (4) @(negedge clk);
      chk("mid_busy", 32'(d4_if.busy), 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("arst_an", 32'(d4_if.an), 32'hF);
      chk("arst_seg", 32'(d4_if.seg), 32'(GB));
      chk("arst_busy", 32'(d4_if.busy), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      busy_len(n);
      chk("busy_len_p9", 32'(n), 32'd10);
      chk_dig4("p9", GB, GZ, GZ, G9);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
